regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-port register-file writeback arbiter (ALU vs load unit), round-robin or fixed-B priority.
// 1-cycle grant-to-write latency; the loser is stalled via its ready and must hold its request.
module regfile_wb_arbiter #(
    parameter int unsigned RR = 1,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          a_valid,
    input  logic [4:0]    a_addr,
    input  logic [31:0]   a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [4:0]    b_addr,
    input  logic [31:0]   b_data,
    output logic          b_ready,
    output logic          reg_write,
    output logic [4:0]    addr,
    output logic [31:0]   write_reg,
    input  logic [4:0]    q_addr1,
    input  logic [4:0]    q_addr2,
    output logic          q_hit1,
    output logic          q_hit2,
    output logic [CW-1:0] conflicts
);

    localparam logic [CW-1:0] CONF_MAX = {CW{1'b1}};

    logic          grant_a;
    logic          grant_b;
    logic          both_vld;

    logic          ptr_q;
    logic          ptr_d;
    logic          we_q;
    logic          we_d;
    logic [4:0]    addr_q;
    logic [4:0]    addr_d;
    logic [31:0]   data_q;
    logic [31:0]   data_d;
    logic [CW-1:0] conf_q;
    logic [CW-1:0] conf_d;

    assign both_vld = a_valid && b_valid;

    // ptr_q=0 favours A, ptr_q=1 favours B; only consulted when both request.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && !hold) begin
            if (both_vld) begin
                if ((RR != 0) && !ptr_q) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (a_valid) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        conf_d = conf_q;
        if (grant_a) begin
            ptr_d  = 1'b1;
            we_d   = (a_addr != 5'd0);
            addr_d = a_addr;
            data_d = a_data;
        end else if (grant_b) begin
            ptr_d  = 1'b0;
            we_d   = (b_addr != 5'd0);
            addr_d = b_addr;
            data_d = b_data;
        end
        if (both_vld && !hold && (conf_q != CONF_MAX)) begin
            conf_d = conf_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= 5'd0;
            data_q <= 32'd0;
            conf_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            conf_q <= conf_d;
        end
    end

    assign reg_write = we_q;
    assign addr      = addr_q;
    assign write_reg = data_q;
    assign conflicts = conf_q;

    // x0 never reports a hit, even though a dropped x0 write still loads addr_q.
    assign q_hit1 = we_q && (addr_q == q_addr1) && (q_addr1 != 5'd0);
    assign q_hit2 = we_q && (addr_q == q_addr2) && (q_addr2 != 5'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: round-robin, fixed-priority and narrow-counter instances on shared stimulus.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset, hold;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr, q_addr1, q_addr2;
    logic [31:0] a_data, b_data;

    logic        m_a_ready, m_b_ready, m_reg_write, m_q_hit1, m_q_hit2;
    logic [4:0]  m_addr;
    logic [31:0] m_write_reg;
    logic [15:0] m_conflicts;

    logic        f_a_ready, f_b_ready, f_reg_write, f_q_hit1, f_q_hit2;
    logic [4:0]  f_addr;
    logic [31:0] f_write_reg;
    logic [15:0] f_conflicts;

    logic        s_a_ready, s_b_ready, s_reg_write, s_q_hit1, s_q_hit2;
    logic [4:0]  s_addr;
    logic [31:0] s_write_reg;
    logic [1:0]  s_conflicts;

    int errors = 0;
    int checks = 0;
    int exp_conf;
    wr_t sb[$];
    wr_t sbf[$];
    wr_t exp_w;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.RR(1), .CW(16)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(m_a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(m_b_ready),
        .reg_write(m_reg_write), .addr(m_addr), .write_reg(m_write_reg),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(m_q_hit1), .q_hit2(m_q_hit2),
        .conflicts(m_conflicts)
    );

    regfile_wb_arbiter #(.RR(0), .CW(16)) dut_fp (
        .clk(clk), .reset(reset), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(f_a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(f_b_ready),
        .reg_write(f_reg_write), .addr(f_addr), .write_reg(f_write_reg),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(f_q_hit1), .q_hit2(f_q_hit2),
        .conflicts(f_conflicts)
    );

    regfile_wb_arbiter #(.RR(1), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(s_b_ready),
        .reg_write(s_reg_write), .addr(s_addr), .write_reg(s_write_reg),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(s_q_hit1), .q_hit2(s_q_hit2),
        .conflicts(s_conflicts)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a_valid = 1'b0;
        b_valid = 1'b0;
        hold    = 1'b0;
    endtask

    task automatic reset_pulse;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        sbf.delete();
        exp_conf = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1; hold = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd3; b_addr = 5'd7; a_data = 32'h1; b_data = 32'h2;
        q_addr1 = 5'd0; q_addr2 = 5'd0;
        tick(); tick();
        checks++;
        if (m_a_ready !== 1'b0 || m_b_ready !== 1'b0)
            begin errors++; $display("FAIL reset_ready got a=%b b=%b want 0 0", m_a_ready, m_b_ready); end
        checks++;
        if ({m_reg_write, m_addr, m_write_reg} !== 38'd0)
            begin errors++; $display("FAIL reset_outputs got we=%b addr=%0d data=%h want zeros", m_reg_write, m_addr, m_write_reg); end
        checks++;
        if (m_conflicts !== 16'd0 || s_conflicts !== 2'd0)
            begin errors++; $display("FAIL reset_conflicts got %0d/%0d want 0", m_conflicts, s_conflicts); end
        exp_conf = 0;
        sb.delete();
    endtask

    // Both valid with addrs 3/7 straight out of reset: A,B,A,B then idle hold of outputs.
    task automatic test_round_robin;
        reset = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd3; a_data = 32'hA000_0003;
        b_addr = 5'd7; b_data = 32'hB000_0007;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (m_a_ready !== (i % 2 == 0) || m_b_ready !== (i % 2 == 1))
                begin errors++; $display("FAIL rr_grant[%0d] got a=%b b=%b want a=%b", i, m_a_ready, m_b_ready, (i % 2 == 0)); end
            if (i % 2 == 0) sb.push_back('{1'b1, 5'd3, 32'hA000_0003});
            else            sb.push_back('{1'b1, 5'd7, 32'hB000_0007});
            tick();
            exp_conf++;
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL rr_sb_empty got none want entry"); end
            else begin
                exp_w = sb.pop_front();
                if ({m_reg_write, m_addr, m_write_reg} !== exp_w)
                    begin errors++; $display("FAIL rr_write[%0d] got %b/%0d/%h want %b/%0d/%h", i, m_reg_write, m_addr, m_write_reg, exp_w.we, exp_w.addr, exp_w.data); end
            end
        end
        checks++;
        if (m_conflicts !== 16'(exp_conf))
            begin errors++; $display("FAIL rr_conflicts got %0d want %0d", m_conflicts, exp_conf); end
        idle_inputs();
        #1;
        sb.push_back('{1'b0, 5'd7, 32'hB000_0007});
        tick();
        checks++;
        exp_w = sb.pop_front();
        if ({m_reg_write, m_addr, m_write_reg} !== exp_w)
            begin errors++; $display("FAIL idle_hold got %b/%0d/%h want %b/%0d/%h", m_reg_write, m_addr, m_write_reg, exp_w.we, exp_w.addr, exp_w.data); end
    endtask

    // A alone moves ptr to B; hold must freeze grants, ptr and conflicts.
    task automatic test_hold;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_9999;
        #1;
        sb.push_back('{1'b1, 5'd9, 32'h0000_9999});
        tick();
        checks++;
        exp_w = sb.pop_front();
        if ({m_reg_write, m_addr, m_write_reg} !== exp_w)
            begin errors++; $display("FAIL hold_pre got %b/%0d/%h want %b/%0d/%h", m_reg_write, m_addr, m_write_reg, exp_w.we, exp_w.addr, exp_w.data); end
        hold = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd3; a_data = 32'hA000_0003; b_addr = 5'd7; b_data = 32'hB000_0007;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (m_a_ready !== 1'b0 || m_b_ready !== 1'b0)
                begin errors++; $display("FAIL hold_ready[%0d] got a=%b b=%b want 0 0", i, m_a_ready, m_b_ready); end
            sb.push_back('{1'b0, 5'd9, 32'h0000_9999});
            tick();
            checks++;
            exp_w = sb.pop_front();
            if ({m_reg_write, m_addr, m_write_reg} !== exp_w || m_conflicts !== 16'(exp_conf))
                begin errors++; $display("FAIL hold_out[%0d] got %b/%0d conf=%0d want %b/%0d conf=%0d", i, m_reg_write, m_addr, m_conflicts, exp_w.we, exp_w.addr, exp_conf); end
        end
        hold = 1'b0;
        #1;
        checks++;
        if (m_a_ready !== 1'b0 || m_b_ready !== 1'b1)
            begin errors++; $display("FAIL hold_ptr got a=%b b=%b want a=0 b=1", m_a_ready, m_b_ready); end
        sb.push_back('{1'b1, 5'd7, 32'hB000_0007});
        tick();
        exp_conf++;
        checks++;
        exp_w = sb.pop_front();
        if ({m_reg_write, m_addr, m_write_reg} !== exp_w || m_conflicts !== 16'(exp_conf))
            begin errors++; $display("FAIL hold_release got %b/%0d conf=%0d want %b/%0d conf=%0d", m_reg_write, m_addr, m_conflicts, exp_w.we, exp_w.addr, exp_conf); end
        idle_inputs();
    endtask

    task automatic test_x0_drop;
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD_BEEF; q_addr1 = 5'd0;
        #1;
        checks++;
        if (m_a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", m_a_ready); end
        sb.push_back('{1'b0, 5'd0, 32'hDEAD_BEEF});
        tick();
        checks++;
        exp_w = sb.pop_front();
        if ({m_reg_write, m_addr, m_write_reg} !== exp_w || m_q_hit1 !== 1'b0)
            begin errors++; $display("FAIL x0_write got %b/%0d/%h hit1=%b want %b/%0d/%h hit1=0", m_reg_write, m_addr, m_write_reg, m_q_hit1, exp_w.we, exp_w.addr, exp_w.data); end
        idle_inputs();
    endtask

    task automatic test_hit;
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h1234_5678;
        q_addr1 = 5'd6; q_addr2 = 5'd5;
        #1;
        checks++;
        if (m_b_ready !== 1'b1 || m_a_ready !== 1'b0) begin errors++; $display("FAIL hit_ready got a=%b b=%b want 0 1", m_a_ready, m_b_ready); end
        sb.push_back('{1'b1, 5'd5, 32'h1234_5678});
        tick();
        checks++;
        exp_w = sb.pop_front();
        if ({m_reg_write, m_addr, m_write_reg} !== exp_w)
            begin errors++; $display("FAIL hit_write got %b/%0d/%h want %b/%0d/%h", m_reg_write, m_addr, m_write_reg, exp_w.we, exp_w.addr, exp_w.data); end
        checks++;
        if (m_q_hit2 !== 1'b1 || m_q_hit1 !== 1'b0)
            begin errors++; $display("FAIL hit_flags got h1=%b h2=%b want 0 1", m_q_hit1, m_q_hit2); end
        idle_inputs();
        tick();
        checks++;
        if (m_q_hit2 !== 1'b0 || m_reg_write !== 1'b0)
            begin errors++; $display("FAIL hit_clear got h2=%b we=%b want 0 0", m_q_hit2, m_reg_write); end
    endtask

    // Same destination on both: winner A writes first, B overrides next cycle.
    task automatic test_same_addr;
        reset_pulse();
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd4; a_data = 32'h0000_1111; b_addr = 5'd4; b_data = 32'h0000_2222;
        #1;
        checks++;
        if (m_a_ready !== 1'b1 || m_b_ready !== 1'b0) begin errors++; $display("FAIL same_first got a=%b b=%b want 1 0", m_a_ready, m_b_ready); end
        sb.push_back('{1'b1, 5'd4, 32'h0000_1111});
        tick();
        exp_conf++;
        a_valid = 1'b0;
        checks++;
        exp_w = sb.pop_front();
        if ({m_reg_write, m_addr, m_write_reg} !== exp_w)
            begin errors++; $display("FAIL same_w1 got %b/%0d/%h want %b/%0d/%h", m_reg_write, m_addr, m_write_reg, exp_w.we, exp_w.addr, exp_w.data); end
        #1;
        sb.push_back('{1'b1, 5'd4, 32'h0000_2222});
        tick();
        checks++;
        exp_w = sb.pop_front();
        if ({m_reg_write, m_addr, m_write_reg} !== exp_w || m_conflicts !== 16'(exp_conf))
            begin errors++; $display("FAIL same_w2 got %b/%0d/%h conf=%0d want %b/%0d/%h conf=%0d", m_reg_write, m_addr, m_write_reg, m_conflicts, exp_w.we, exp_w.addr, exp_w.data, exp_conf); end
        idle_inputs();
    endtask

    task automatic test_fixed_priority;
        reset_pulse();
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd3; a_data = 32'hA000_0003; b_addr = 5'd7; b_data = 32'hB000_0007;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (f_b_ready !== 1'b1 || f_a_ready !== 1'b0)
                begin errors++; $display("FAIL fp_grant[%0d] got a=%b b=%b want 0 1", i, f_a_ready, f_b_ready); end
            sbf.push_back('{1'b1, 5'd7, 32'hB000_0007});
            tick();
            checks++;
            exp_w = sbf.pop_front();
            if ({f_reg_write, f_addr, f_write_reg} !== exp_w)
                begin errors++; $display("FAIL fp_write[%0d] got %b/%0d/%h want %b/%0d/%h", i, f_reg_write, f_addr, f_write_reg, exp_w.we, exp_w.addr, exp_w.data); end
        end
        checks++;
        if (f_conflicts !== 16'd3) begin errors++; $display("FAIL fp_conflicts got %0d want 3", f_conflicts); end
        idle_inputs();
    endtask

    task automatic test_saturate;
        logic [1:0] exp_sat;
        reset_pulse();
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd3; a_data = 32'hA000_0003; b_addr = 5'd7; b_data = 32'hB000_0007;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_sat = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (s_conflicts !== exp_sat)
                begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", i, s_conflicts, exp_sat); end
        end
        checks++;
        if (s_reg_write !== 1'b1) begin errors++; $display("FAIL sat_inflight got %b want 1", s_reg_write); end
        reset = 1'b1;
        #1;
        checks++;
        if (s_a_ready !== 1'b0 || s_b_ready !== 1'b0)
            begin errors++; $display("FAIL sat_reset_ready got a=%b b=%b want 0 0", s_a_ready, s_b_ready); end
        tick();
        checks++;
        if (s_reg_write !== 1'b0 || s_conflicts !== 2'd0 || s_addr !== 5'd0)
            begin errors++; $display("FAIL sat_reset got we=%b conf=%0d addr=%0d want 0 0 0", s_reg_write, s_conflicts, s_addr); end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_hold();
        test_x0_drop();
        test_hit();
        test_same_addr();
        test_fixed_priority();
        test_saturate();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
